aes_enc_round_ctrl: RTL and testbench

Sequencer for the iterative AES-128 encryption core. It accepts a plaintext block over a valid/ready handshake, fetches round keys from the key schedule over a request/acknowledge handshake, and drives the shared combinational round datapath (SubBytes → ShiftRows → MixColumns → AddRoundKey) for rounds 1–10. It holds the 128-bit state register and presents the ciphertext on a valid/ready output port. It sits between the block interface and the round-function/key-expansion logic.

---
 rtl/aes_enc_round_ctrl.sv | 147 ++++++++++++++
 tb/tb_aes_enc_round_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_enc_round_ctrl.sv
// Round sequencer for the iterative AES-128 encryption core: owns the state register and round counter.
// Optional round-key cache is built when AES_ENC_CTRL_KEYCACHE_EN is defined.
module aes_enc_round_ctrl #(
   parameter int NR = 10
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] pt,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] ct,
   output logic         rk_req,
   output logic [3:0]   rk_idx,
   input  logic         rk_ack,
   input  logic [127:0] rk,
   input  logic         key_inv,
   output logic [127:0] st,
   output logic [127:0] rkey,
   output logic         rnd_last,
   input  logic [127:0] rnd_in
);

   // Handshakes: a transfer happens on a rising edge where valid and ready (req and ack) are both
   // high; a source holds valid/data until then, and in_ready/out_valid/rk_req depend only on state.
   typedef enum logic [2:0] {IDLE, KEY, ROUND, DONE, CINIT} state_t;

   localparam logic [3:0] NR4 = 4'(NR);

   state_t       state, state_n;
   logic [3:0]   rnd, rnd_n, rnd_inc;
   logic [127:0] st_n, rkey_n;
   logic         use_cache, use_cache_n;
   logic         cache_hit;
   logic [127:0] cache_k0, cache_knext;

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign rk_req    = (state == KEY);
   assign rk_idx    = rk_req ? rnd : 4'd0;
   assign ct        = st;
   assign rnd_inc   = (rnd == NR4) ? rnd : rnd + 4'd1;

`ifdef AES_ENC_CTRL_KEYCACHE_EN
   logic [127:0] cache [0:NR];
   logic         cache_valid, inv_seen;

   assign cache_hit   = cache_valid;
   assign cache_k0    = cache[0];
   assign cache_knext = cache[rnd_inc];

   always_ff @(posedge clk) begin
      if (state == KEY && rk_ack) cache[rnd] <= rk;
   end

   // A block only validates the cache if no key change arrived while it was being filled.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cache_valid <= 1'b0;
         inv_seen    <= 1'b0;
      end else begin
         if (state == IDLE && in_valid) inv_seen <= key_inv;
         else if (key_inv)              inv_seen <= 1'b1;
         if (key_inv)
            cache_valid <= 1'b0;
         else if (state == ROUND && rnd == NR4 && !use_cache && !inv_seen)
            cache_valid <= 1'b1;
      end
   end
`else
   logic unused_key_inv;
   assign unused_key_inv = key_inv;
   assign cache_hit      = 1'b0;
   assign cache_k0       = '0;
   assign cache_knext    = '0;
`endif

   always_comb begin
      state_n     = state;
      st_n        = st;
      rnd_n       = rnd;
      rkey_n      = rkey;
      use_cache_n = use_cache;
      case (state)
         IDLE: begin
            if (in_valid) begin
               st_n        = pt;
               rnd_n       = 4'd0;
               use_cache_n = cache_hit;
               state_n     = cache_hit ? CINIT : KEY;
            end
         end
         KEY: begin
            if (rk_ack) begin
               if (rnd == 4'd0) begin
                  st_n  = st ^ rk;
                  rnd_n = 4'd1;
               end else begin
                  rkey_n  = rk;
                  state_n = ROUND;
               end
            end
         end
         CINIT: begin
            // rkey is loaded one cycle ahead so ROUND can run back-to-back from the cache.
            st_n    = st ^ cache_k0;
            rnd_n   = 4'd1;
            rkey_n  = cache_knext;
            state_n = ROUND;
         end
         ROUND: begin
            st_n = rnd_in;
            if (rnd == NR4) begin
               state_n = DONE;
            end else begin
               rnd_n = rnd_inc;
               if (use_cache) rkey_n = cache_knext;
               else           state_n = KEY;
            end
         end
         DONE: begin
            if (out_ready) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         st        <= '0;
         rkey      <= '0;
         rnd       <= 4'd0;
         rnd_last  <= 1'b0;
         use_cache <= 1'b0;
      end else begin
         state     <= state_n;
         st        <= st_n;
         rkey      <= rkey_n;
         rnd       <= rnd_n;
         rnd_last  <= (rnd_n == NR4);
         use_cache <= use_cache_n;
      end
   end

endmodule

// File: tb/tb_aes_enc_round_ctrl.sv
// Bench for aes_enc_round_ctrl: models the AES round datapath and key schedule, scoreboards ciphertexts.
// Cache scenarios are included when AES_ENC_CTRL_KEYCACHE_EN is defined.
module tb_aes_enc_round_ctrl;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid, in_ready, out_valid, out_ready;
   logic [127:0] pt, ct, rk, st, rkey, rnd_in;
   logic         rk_req, rk_ack, key_inv, rnd_last;
   logic [3:0]   rk_idx;

   int           cyc = 0;
   int           n_tests = 0;
   int           n_fail = 0;
   logic [127:0] exp_q[$];
   int           idx_log[$];
   int           req_cnt, total_delay, acc_cyc;
   bit           delay_mode, junk_mode;
   logic [127:0] rks [0:10];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   aes_enc_round_ctrl #(.NR(10)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .pt(pt),
      .out_valid(out_valid), .out_ready(out_ready), .ct(ct), .rk_req(rk_req),
      .rk_idx(rk_idx), .rk_ack(rk_ack), .rk(rk), .key_inv(key_inv), .st(st),
      .rkey(rkey), .rnd_last(rnd_last), .rnd_in(rnd_in)
   );

   // ---------------- AES reference model ----------------
   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         a = xt(a);
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
      logic [15:0] d = {v, v};
      return d[15-n -: 8];
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] inv = 8'h01;
      for (int i = 0; i < 254; i++) inv = gmul(inv, x);
      if (x == 8'h00) inv = 8'h00;
      return inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
   endfunction

   function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                              input logic last);
      logic [7:0]   a [16];
      logic [7:0]   b [16];
      logic [7:0]   c [16];
      logic [127:0] res;
      for (int i = 0; i < 16; i++) a[i] = sbox(s[127-8*i -: 8]);
      for (int col = 0; col < 4; col++)
         for (int r = 0; r < 4; r++) b[r+4*col] = a[r+4*((col+r)%4)];
      for (int col = 0; col < 4; col++) begin
         if (last) begin
            for (int r = 0; r < 4; r++) c[r+4*col] = b[r+4*col];
         end else begin
            c[4*col]   = xt(b[4*col]) ^ xt(b[4*col+1]) ^ b[4*col+1] ^ b[4*col+2] ^ b[4*col+3];
            c[4*col+1] = b[4*col] ^ xt(b[4*col+1]) ^ xt(b[4*col+2]) ^ b[4*col+2] ^ b[4*col+3];
            c[4*col+2] = b[4*col] ^ b[4*col+1] ^ xt(b[4*col+2]) ^ xt(b[4*col+3]) ^ b[4*col+3];
            c[4*col+3] = xt(b[4*col]) ^ b[4*col] ^ b[4*col+1] ^ b[4*col+2] ^ xt(b[4*col+3]);
         end
      end
      for (int i = 0; i < 16; i++) res[127-8*i -: 8] = c[i] ^ k[127-8*i -: 8];
      return res;
   endfunction

   task automatic expand_key(input logic [127:0] key);
      logic [31:0] w [44];
      logic [31:0] t;
      logic [7:0]  rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0]), sbox(t[31:24])} ^ {rc, 24'h0};
            rc = xt(rc);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r < 11; r++) rks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   function automatic logic [127:0] aes_enc(input logic [127:0] p);
      logic [127:0] s = p ^ rks[0];
      for (int r = 1; r <= 10; r++) s = aes_round(s, rks[r], r == 10);
      return s;
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // External combinational round datapath.
   assign rnd_in = aes_round(st, rkey, rnd_last);

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // ---------------- key schedule responder ----------------
   initial begin : key_resp
      bit           busy = 1'b0;
      int           wait_left = 0;
      logic [127:0] st_hold = '0;
      rk_ack = 1'b0;
      rk     = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            rk_ack = 1'b0;
            busy   = 1'b0;
         end else if (rk_req) begin
            req_cnt++;
            if (!busy) begin
               busy      = 1'b1;
               wait_left = delay_mode ? $urandom_range(0, 5) : 0;
               total_delay += wait_left;
            end else begin
               check("st_frozen", st, st_hold);
            end
            if (wait_left == 0) begin
               rk_ack = 1'b1;
               rk     = rks[rk_idx];
               idx_log.push_back(int'(rk_idx));
               busy   = 1'b0;
            end else begin
               rk_ack  = 1'b0;
               rk      = rand128();
               st_hold = st;
               wait_left--;
            end
         end else begin
            busy   = 1'b0;
            rk_ack = junk_mode ? 1'($urandom_range(0, 1)) : 1'b0;
            rk     = rand128();
         end
      end
   end

   // ---------------- driver / scoreboard tasks ----------------
   task automatic pulse_inv();
      @(negedge clk);
      key_inv = 1'b1;
      @(negedge clk);
      key_inv = 1'b0;
   endtask

   task automatic send(input logic [127:0] p, input logic [127:0] e);
      idx_log.delete();
      req_cnt     = 0;
      total_delay = 0;
      exp_q.push_back(e);
      @(negedge clk);
      in_valid = 1'b1;
      pt       = p;
      for (int n = 0; n < 100 && !in_ready; n++) @(negedge clk);
      if (!in_ready) check("accept_timeout", 128'(in_ready), 128'd1);
      acc_cyc = cyc;
      @(negedge clk);
      in_valid = 1'b0;
      pt       = rand128();
   endtask

   task automatic receive(input bit cached, input int hold);
      logic [127:0] got, e;
      int           lat;
      for (int n = 0; n < 300 && !out_valid; n++) @(negedge clk);
      check("out_valid_seen", 128'(out_valid), 128'd1);
      lat = cyc - acc_cyc;
      check("latency", 128'(lat), cached ? 128'd12 : 128'(22 + total_delay));
      got = ct;
      e   = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      check("ct", got, e);
      if (cached) begin
         check("cached_rk_req_cycles", 128'(req_cnt), 128'd0);
      end else begin
         check("rk_idx_count", 128'(idx_log.size()), 128'd11);
         for (int i = 0; i < 11 && i < idx_log.size(); i++)
            check("rk_idx_seq", 128'(idx_log[i]), 128'(i));
      end
      for (int i = 0; i < hold; i++) begin
         in_valid = 1'($urandom_range(0, 1));
         pt       = rand128();
         @(negedge clk);
         check("hold_out_valid", 128'(out_valid), 128'd1);
         check("hold_ct", ct, got);
         check("hold_in_ready", 128'(in_ready), 128'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("post_out_valid", 128'(out_valid), 128'd0);
      check("post_in_ready", 128'(in_ready), 128'd1);
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // ---------------- directed sequence ----------------
   initial begin : main
      logic [127:0] p;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; key_inv = 1'b0; pt = '0;
      delay_mode = 1'b0; junk_mode = 1'b0;
      expand_key(128'h000102030405060708090a0b0c0d0e0f);
      repeat (2) @(negedge clk);
      check("rst_in_ready", 128'(in_ready), 128'd1);
      check("rst_out_valid", 128'(out_valid), 128'd0);
      check("rst_rk_req", 128'(rk_req), 128'd0);
      check("rst_rnd_last", 128'(rnd_last), 128'd0);
      check("rst_rk_idx", 128'(rk_idx), 128'd0);
      check("rst_st", st, 128'd0);
      check("rst_rkey", rkey, 128'd0);
      check("rst_ct", ct, 128'd0);
      rst = 1'b0;

      // FIPS-197 C.1 with immediate ack
      pulse_inv();
      send(128'h00112233445566778899aabbccddeeff, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
      receive(1'b0, 0);

      // random ack delays, stray acks outside KEY
      delay_mode = 1'b1;
      junk_mode  = 1'b1;
      for (int b = 0; b < 3; b++) begin
         pulse_inv();
         p = (b == 0) ? 128'h00112233445566778899aabbccddeeff : rand128();
         send(p, aes_enc(p));
         receive(1'b0, 0);
      end
      delay_mode = 1'b0;
      junk_mode  = 1'b0;

      // sink back-pressure with ignored in_valid pulses
      pulse_inv();
      p = rand128();
      send(p, aes_enc(p));
      receive(1'b0, 10);

      // reset in ROUND with rnd = 5 (cycle 11 after accept)
      pulse_inv();
      p = rand128();
      send(p, aes_enc(p));
      while (cyc < acc_cyc + 11) @(negedge clk);
      check("pre_rst_rk_req", 128'(rk_req), 128'd0);
      rst = 1'b1;
      #1;
      check("mid_rst_in_ready", 128'(in_ready), 128'd1);
      check("mid_rst_out_valid", 128'(out_valid), 128'd0);
      check("mid_rst_rk_req", 128'(rk_req), 128'd0);
      check("mid_rst_st", st, 128'd0);
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      p = rand128();
      send(p, aes_enc(p));
      receive(1'b0, 0);

`ifdef AES_ENC_CTRL_KEYCACHE_EN
      // fill, then cached block
      pulse_inv();
      p = rand128(); send(p, aes_enc(p)); receive(1'b0, 0);
      p = rand128(); send(p, aes_enc(p)); receive(1'b1, 0);
      // invalidate, handshake refill, then cached block with key_inv mid-block
      pulse_inv();
      p = rand128(); send(p, aes_enc(p)); receive(1'b0, 0);
      p = rand128(); send(p, aes_enc(p));
      key_inv = 1'b1; @(negedge clk); key_inv = 1'b0;
      receive(1'b1, 0);
      // key_inv during a filling block keeps the next block in handshake mode
      p = rand128(); send(p, aes_enc(p));
      key_inv = 1'b1; @(negedge clk); key_inv = 1'b0;
      receive(1'b0, 0);
      p = rand128(); send(p, aes_enc(p)); receive(1'b0, 0);
`endif

      check("scoreboard_empty", 128'(exp_q.size()), 128'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
